// File: rtl/map_pkg.sv
// map_pkg: shared map geometry, tile codes, arbiter state encoding and the
// tile extract/insert helpers used by the map RMW arbiter.
package map_pkg;

    localparam int MAP_ROWS  = 30;
    localparam int MAP_COLS  = 40;
    localparam int TILE_W    = 4;
    localparam int ROW_W     = 160;
    localparam int ROW_IDX_W = 5;
    localparam int COL_IDX_W = 6;

    typedef enum logic [TILE_W-1:0] {
        TILE_EMPTY  = 4'h0,
        TILE_WALL   = 4'h1,
        TILE_DOT    = 4'h2,
        TILE_PILL   = 4'h3,
        TILE_PACMAN = 4'h4,
        TILE_GHOST  = 4'h5
    } tile_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } arb_state_t;

    // Column 0 lives in the MSBs: shifting left by 4*col brings the wanted
    // tile to the top nibble.
    function automatic logic [TILE_W-1:0] get_tile(input logic [ROW_W-1:0] row,
                                                   input logic [COL_IDX_W-1:0] col);
        logic [ROW_W-1:0] sh;
        sh = row << {col, 2'b00};
        return sh[ROW_W-1 -: TILE_W];
    endfunction

    // Replace one tile, leaving the other 156 bits untouched.
    function automatic logic [ROW_W-1:0] put_tile(input logic [ROW_W-1:0]     row,
                                                  input logic [COL_IDX_W-1:0] col,
                                                  input logic [TILE_W-1:0]    tile);
        logic [ROW_W-1:0] mask;
        logic [ROW_W-1:0] val;
        mask = {{TILE_W{1'b1}}, {(ROW_W-TILE_W){1'b0}}} >> {col, 2'b00};
        val  = {tile, {(ROW_W-TILE_W){1'b0}}} >> {col, 2'b00};
        return (row & ~mask) | val;
    endfunction

endpackage

// File: rtl/map_rmw_arbiter_if.sv
// map_rmw_arbiter_if: requester-side and RAM port-B signals of the map RMW
// arbiter.
//   req/req_row/req_col/req_tile : per-client request level and operands
//   grant/done                   : one-hot grant (whole transaction), done pulse
//   old_tile/err                 : result, valid in the done cycle
//   busy                         : arbiter not idle
//   ram_addr/ram_wrdata/ram_wren : port-B address, write data, write enable
//   ram_rddata                   : port-B read data
// slave = arbiter side, master = requesters + RAM side.
interface map_rmw_arbiter_if #(
    parameter int NUM_REQ = 3
);
    import map_pkg::*;

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*ROW_IDX_W-1:0] req_row;
    logic [NUM_REQ*COL_IDX_W-1:0] req_col;
    logic [NUM_REQ*TILE_W-1:0]    req_tile;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           done;
    logic [TILE_W-1:0]            old_tile;
    logic                         err;
    logic                         busy;
    logic [ROW_IDX_W-1:0]         ram_addr;
    logic [ROW_W-1:0]             ram_wrdata;
    logic                         ram_wren;
    logic [ROW_W-1:0]             ram_rddata;

    modport slave (
        input  req, req_row, req_col, req_tile, ram_rddata,
        output grant, done, old_tile, err, busy, ram_addr, ram_wrdata, ram_wren
    );

    modport master (
        output req, req_row, req_col, req_tile, ram_rddata,
        input  grant, done, old_tile, err, busy, ram_addr, ram_wrdata, ram_wren
    );

endinterface

// File: rtl/map_rmw_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   i_req    : request vector
//   i_ptr    : highest-priority index this round
//   i_enable : when low, no grant is produced
//   o_grant  : one-hot grant
//   o_winner : index of the granted requester
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_winner
);

    logic w_found;
    int   w_idx;

    // Scan NUM_REQ slots starting at i_ptr, wrapping; first set bit wins.
    always_comb begin
        o_grant  = '0;
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        if (i_enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx = (int'(i_ptr) + k) % NUM_REQ;
                if (!w_found && i_req[w_idx]) begin
                    w_found         = 1'b1;
                    o_grant[w_idx]  = 1'b1;
                    o_winner        = IDX_W'(w_idx);
                end
            end
        end
    end

endmodule

// File: rtl/map_rmw_arbiter.sv
// map_rmw_arbiter: shares map RAM port B between tile-update clients; each
// request is one atomic read-modify-write of a 4-bit tile in a 160-bit row,
// returning the overwritten tile.
//   CLOCK_50 : clock
//   reset_n  : async active-low reset; abandons any in-flight transaction
//   bus      : map_rmw_arbiter_if.slave (requests, results, RAM port B)
module map_rmw_arbiter
    import map_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int RD_LAT  = 2,
    parameter int ROWS    = MAP_ROWS,
    parameter int COLS    = MAP_COLS
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    map_rmw_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 2;
    localparam logic [ROW_IDX_W-1:0] ROW_LIM = ROW_IDX_W'(ROWS);
    localparam logic [COL_IDX_W-1:0] COL_LIM = COL_IDX_W'(COLS);

    arb_state_t r_state, w_state_nxt;

    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_done;
    logic [IDX_W-1:0]     r_win;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [COL_IDX_W-1:0] r_col;
    logic [TILE_W-1:0]    r_tile;
    logic [TILE_W-1:0]    r_old;
    logic                 r_err;
    logic [CNT_W-1:0]     r_cnt;
    logic [ROW_IDX_W-1:0] r_addr;
    logic [ROW_W-1:0]     r_wrdata;
    logic                 r_wren;

    logic [NUM_REQ-1:0]   w_gnt;
    logic [IDX_W-1:0]     w_win;
    logic                 w_arb_en;
    logic [ROW_IDX_W-1:0] w_row_a  [NUM_REQ];
    logic [COL_IDX_W-1:0] w_col_a  [NUM_REQ];
    logic [TILE_W-1:0]    w_tile_a [NUM_REQ];
    logic [ROW_IDX_W-1:0] w_row;
    logic [COL_IDX_W-1:0] w_col;
    logic [TILE_W-1:0]    w_tile;
    logic                 w_oor;
    logic [TILE_W-1:0]    w_rd_tile;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_row_a[g]  = bus.req_row[g*ROW_IDX_W +: ROW_IDX_W];
        assign w_col_a[g]  = bus.req_col[g*COL_IDX_W +: COL_IDX_W];
        assign w_tile_a[g] = bus.req_tile[g*TILE_W +: TILE_W];
    end

    assign w_arb_en = (r_state == ST_IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req    (bus.req),
        .i_ptr    (r_rr_ptr),
        .i_enable (w_arb_en),
        .o_grant  (w_gnt),
        .o_winner (w_win)
    );

    assign w_row     = w_row_a[w_win];
    assign w_col     = w_col_a[w_win];
    assign w_tile    = w_tile_a[w_win];
    assign w_oor     = (w_row >= ROW_LIM) || (w_col >= COL_LIM);
    assign w_rd_tile = get_tile(bus.ram_rddata, r_col);

    // State register
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state; out-of-range requests bypass the RAM entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (|bus.req) w_state_nxt = w_oor ? ST_DONE : ST_READ;
            ST_READ:  w_state_nxt = ST_WAIT;
            ST_WAIT:  if (r_cnt == '0) w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath. Operands are latched once in IDLE so requesters may change
    // their inputs freely while a transaction runs.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_grant  <= '0;
            r_done   <= '0;
            r_win    <= '0;
            r_rr_ptr <= '0;
            r_col    <= '0;
            r_tile   <= '0;
            r_old    <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wrdata <= '0;
            r_wren   <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_grant <= w_gnt;
                        r_win   <= w_win;
                        r_col   <= w_col;
                        r_tile  <= w_tile;
                        r_old   <= '0;
                        if (w_oor) begin
                            r_err  <= 1'b1;
                            r_done <= w_gnt;
                        end else begin
                            r_err  <= 1'b0;
                            r_addr <= w_row;
                        end
                    end
                end
                ST_READ: r_cnt <= CNT_W'(RD_LAT - 1);
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_old    <= w_rd_tile;
                        r_wrdata <= put_tile(bus.ram_rddata, r_col, r_tile);
                        // Rewriting an identical tile is pointless; skip it.
                        r_wren   <= (r_tile != w_rd_tile);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_wren <= 1'b0;
                    r_done <= r_grant;
                end
                ST_DONE: begin
                    r_grant  <= '0;
                    r_rr_ptr <= (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.done       = r_done;
    assign bus.old_tile   = r_old;
    assign bus.err        = r_err;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.ram_addr   = r_addr;
    assign bus.ram_wrdata = r_wrdata;
    assign bus.ram_wren   = r_wren;

endmodule

// File: tb/tb_map_rmw_arbiter.sv
module tb_map_rmw_arbiter;
    import map_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int RD_LAT  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    map_rmw_arbiter_if #(.NUM_REQ(NUM_REQ)) bif();

    map_rmw_arbiter #(
        .NUM_REQ (NUM_REQ),
        .RD_LAT  (RD_LAT),
        .ROWS    (30),
        .COLS    (40)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .bus      (bif)
    );

    // Map RAM port-B model: registered read with RD_LAT-cycle latency.
    logic [159:0] mem  [0:31];
    logic [159:0] pipe [0:RD_LAT-1];
    logic         pl_en = 1'b0;
    logic [4:0]   pl_addr = '0;
    logic [159:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en)             mem[pl_addr]      <= pl_data;
        else if (bif.ram_wren) mem[bif.ram_addr] <= bif.ram_wrdata;
        pipe[0] <= mem[bif.ram_addr];
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bif.ram_rddata = pipe[RD_LAT-1];

    // Monitors
    int bad_gnt  = 0;
    int wren_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (!$onehot0(bif.grant)) bad_gnt++;
        if (bif.ram_wren) wren_cnt++;
        if (|bif.done) done_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [159:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic drive(input int c, input logic [4:0] row, input logic [5:0] col,
                         input logic [3:0] tile);
        bif.req_row[5*c +: 5]  = row;
        bif.req_col[6*c +: 6]  = col;
        bif.req_tile[4*c +: 4] = tile;
        bif.req[c]             = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (bif.grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", bif.grant); end
        n_checks++; if (bif.done !== 3'b000) begin n_fail++; $display("FAIL reset_done: got %b want 000", bif.done); end
        n_checks++; if ({bif.busy, bif.err, bif.ram_wren} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {bif.busy, bif.err, bif.ram_wren}); end
        n_checks++; if (bif.old_tile !== 4'h0 || bif.ram_addr !== 5'd0) begin n_fail++; $display("FAIL reset_old_addr: got %h/%0d want 0/0", bif.old_tile, bif.ram_addr); end
        n_checks++; if (bif.ram_wrdata !== 160'h0) begin n_fail++; $display("FAIL reset_wrdata: got %h want 0", bif.ram_wrdata); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        preload(5'd3, {4'hA, 156'h0});
        drive(0, 5'd3, 6'd0, 4'h5);
        tick();
        n_checks++; if (bif.busy !== 1'b1 || bif.grant !== 3'b001) begin n_fail++; $display("FAIL single_c1_grant: got busy=%b grant=%b want 1/001", bif.busy, bif.grant); end
        n_checks++; if (bif.ram_addr !== 5'd3 || bif.ram_wren !== 1'b0) begin n_fail++; $display("FAIL single_c1_addr: got addr=%0d wren=%b want 3/0", bif.ram_addr, bif.ram_wren); end
        tick(); tick();
        n_checks++; if (bif.ram_wren !== 1'b0) begin n_fail++; $display("FAIL single_c3_wren: got %b want 0", bif.ram_wren); end
        tick();
        n_checks++; if (bif.ram_wren !== 1'b1) begin n_fail++; $display("FAIL single_c4_wren: got %b want 1", bif.ram_wren); end
        n_checks++; if (bif.ram_wrdata !== {4'h5, 156'h0}) begin n_fail++; $display("FAIL single_c4_wrdata: got %h want %h", bif.ram_wrdata, {4'h5, 156'h0}); end
        tick();
        n_checks++; if (bif.done !== 3'b001) begin n_fail++; $display("FAIL single_c5_done: got %b want 001", bif.done); end
        n_checks++; if (bif.old_tile !== 4'hA || bif.err !== 1'b0) begin n_fail++; $display("FAIL single_c5_old: got old=%h err=%b want A/0", bif.old_tile, bif.err); end
        bif.req = '0;
        tick();
        n_checks++; if (bif.done !== 3'b000 || bif.busy !== 1'b0) begin n_fail++; $display("FAIL single_c6_idle: got done=%b busy=%b want 000/0", bif.done, bif.busy); end
        n_checks++; if (mem[3] !== {4'h5, 156'h0}) begin n_fail++; $display("FAIL single_mem: got %h want %h", mem[3], {4'h5, 156'h0}); end
    endtask

    task automatic test_last_col();
        preload(5'd29, {160{1'b1}});
        drive(1, 5'd29, 6'd39, 4'h2);
        tick(); tick(); tick(); tick();
        n_checks++; if (bif.ram_wren !== 1'b1 || bif.ram_wrdata !== {{156{1'b1}}, 4'h2}) begin n_fail++; $display("FAIL lastcol_write: got wren=%b data=%h want 1/%h", bif.ram_wren, bif.ram_wrdata, {{156{1'b1}}, 4'h2}); end
        tick();
        n_checks++; if (bif.done !== 3'b010 || bif.old_tile !== 4'hF || bif.err !== 1'b0) begin n_fail++; $display("FAIL lastcol_done: got done=%b old=%h err=%b want 010/F/0", bif.done, bif.old_tile, bif.err); end
        bif.req = '0;
        tick();
        n_checks++; if (mem[29] !== {{156{1'b1}}, 4'h2}) begin n_fail++; $display("FAIL lastcol_mem: got %h want %h", mem[29], {{156{1'b1}}, 4'h2}); end
    endtask

    task automatic test_out_of_range();
        int w0;
        w0 = wren_cnt;
        drive(2, 5'd30, 6'd0, 4'h1);
        tick();
        n_checks++; if (bif.done !== 3'b100 || bif.err !== 1'b1 || bif.old_tile !== 4'h0) begin n_fail++; $display("FAIL oor_row: got done=%b err=%b old=%h want 100/1/0", bif.done, bif.err, bif.old_tile); end
        n_checks++; if (bif.busy !== 1'b1) begin n_fail++; $display("FAIL oor_row_busy: got %b want 1", bif.busy); end
        bif.req = '0;
        tick();
        n_checks++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL oor_row_idle: got busy=%b want 0", bif.busy); end
        drive(0, 5'd0, 6'd40, 4'h1);
        tick();
        n_checks++; if (bif.done !== 3'b001 || bif.err !== 1'b1) begin n_fail++; $display("FAIL oor_col: got done=%b err=%b want 001/1", bif.done, bif.err); end
        bif.req = '0;
        tick();
        n_checks++; if (wren_cnt !== w0) begin n_fail++; $display("FAIL oor_no_write: got %0d write cycles want %0d", wren_cnt, w0); end
    endtask

    task automatic test_same_tile();
        logic [159:0] row;
        int w0;
        row = '0;
        row[139 -: 4] = 4'h3;
        preload(5'd7, row);
        w0 = wren_cnt;
        drive(1, 5'd7, 6'd5, 4'h3);
        tick(); tick(); tick(); tick(); tick();
        n_checks++; if (bif.done !== 3'b010 || bif.old_tile !== 4'h3 || bif.err !== 1'b0) begin n_fail++; $display("FAIL same_done: got done=%b old=%h err=%b want 010/3/0", bif.done, bif.old_tile, bif.err); end
        bif.req = '0;
        tick();
        n_checks++; if (wren_cnt !== w0) begin n_fail++; $display("FAIL same_no_write: got %0d write cycles want %0d", wren_cnt, w0); end
        n_checks++; if (mem[7] !== row) begin n_fail++; $display("FAIL same_mem: got %h want %h", mem[7], row); end
    endtask

    task automatic test_back_to_back();
        int last, cyc, exp_c;
        logic got;
        logic [2:0] exp_g;
        preload(5'd10, 160'h0);
        preload(5'd11, 160'h0);
        preload(5'd12, 160'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(0, 5'd10, 6'd1, 4'h1);
        drive(1, 5'd11, 6'd2, 4'h2);
        drive(2, 5'd12, 6'd3, 4'h3);
        last = 0;
        cyc  = 0;
        for (int n = 0; n < 6; n++) begin
            exp_c = n % NUM_REQ;
            exp_g = 3'b001 << exp_c;
            got   = 1'b0;
            for (int w = 0; w < 20 && !got; w++) begin
                tick();
                cyc++;
                if (bif.done !== 3'b000) got = 1'b1;
            end
            n_checks++; if (!got || bif.done !== exp_g) begin n_fail++; $display("FAIL b2b_order%0d: got done=%b want %b", n, bif.done, exp_g); end
            n_checks++; if (cyc - last !== ((n == 0) ? 5 : RD_LAT + 4)) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d cycles want %0d", n, cyc - last, (n == 0) ? 5 : RD_LAT + 4); end
            last = cyc;
        end
        bif.req = '0;
        tick();
        n_checks++; if (bad_gnt !== 0) begin n_fail++; $display("FAIL grant_onehot: got %0d bad cycles want 0", bad_gnt); end
    endtask

    task automatic test_reset_mid();
        int d0;
        logic got;
        preload(5'd20, 160'h0);
        drive(0, 5'd31, 6'd0, 4'h1);
        tick();
        n_checks++; if (bif.done !== 3'b001) begin n_fail++; $display("FAIL mid_pre_done: got %b want 001", bif.done); end
        bif.req = '0;
        tick();
        drive(2, 5'd20, 6'd2, 4'h4);
        tick(); tick(); tick(); tick();
        n_checks++; if (bif.ram_wren !== 1'b1) begin n_fail++; $display("FAIL mid_write_phase: got wren=%b want 1", bif.ram_wren); end
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bif.ram_wren !== 1'b0 || bif.busy !== 1'b0 || bif.grant !== 3'b000) begin n_fail++; $display("FAIL mid_reset_drop: got wren=%b busy=%b grant=%b want 0/0/000", bif.ram_wren, bif.busy, bif.grant); end
        bif.req = '0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (done_cnt !== d0 || bif.busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: got done pulses=%0d busy=%b want %0d/0", done_cnt, bif.busy, d0); end
        drive(0, 5'd20, 6'd0, 4'h1);
        drive(1, 5'd20, 6'd1, 4'h2);
        drive(2, 5'd20, 6'd2, 4'h3);
        tick();
        n_checks++; if (bif.grant !== 3'b001) begin n_fail++; $display("FAIL mid_ptr_zero: got grant=%b want 001", bif.grant); end
        bif.req[1] = 1'b0;
        bif.req[2] = 1'b0;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            tick();
            if (bif.done !== 3'b000) got = 1'b1;
        end
        n_checks++; if (!got || bif.done !== 3'b001 || bif.old_tile !== 4'h0) begin n_fail++; $display("FAIL mid_after_done: got done=%b old=%h want 001/0", bif.done, bif.old_tile); end
        bif.req = '0;
        tick(); tick();
        n_checks++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL mid_dropped_ignored: got busy=%b want 0", bif.busy); end
    endtask

    initial begin
        bif.req      = '0;
        bif.req_row  = '0;
        bif.req_col  = '0;
        bif.req_tile = '0;
        test_reset();
        test_single();
        test_last_col();
        test_out_of_range();
        test_same_tile();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
